// File: rtl/worley_pkg.sv
// Shared types and init tables for the Worley feature-point animator.
package worley_pkg;

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

  typedef enum logic [1:0] {F_X, F_Y, F_VX, F_VY} init_field_t;

  localparam int unsigned X_MAX_DEF = 639;
  localparam int unsigned Y_MAX_DEF = 479;

  function automatic int pick4(input int unsigned i, input int a, input int b,
                               input int c, input int d);
    case (i[1:0])
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  // Points 4..7 repeat 0..3 shifted right by 8 pixels.
  function automatic int init_val(input int unsigned i, input init_field_t f);
    case (f)
      F_X:     return pick4(i, 100, 300, 500, 100) + ((i >= 4) ? 8 : 0);
      F_Y:     return pick4(i, 100, 200, 400, 430);
      F_VX:    return pick4(i, 3, -1, 2, -2);
      default: return pick4(i, -2, 1, -1, -3);
    endcase
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One-axis position step with reflection off 0 and max_p.
module bounce_axis #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned VEL_W   = 4
) (
  input  logic        [COORD_W-1:0] p,
  input  logic signed [VEL_W-1:0]   v,
  input  logic        [COORD_W-1:0] max_p,
  output logic        [COORD_W-1:0] p_next,
  output logic signed [VEL_W-1:0]   v_next
);
  localparam int unsigned W = COORD_W + 2;

  logic signed [W-1:0] n;
  logic signed [W-1:0] max_s;

  always_comb begin
    max_s  = $signed({2'b00, max_p});
    n      = $signed({2'b00, p}) + $signed({{(W-VEL_W){v[VEL_W-1]}}, v});
    p_next = n[COORD_W-1:0];
    v_next = v;
    if (n < 0) begin
      p_next = COORD_W'(-n);
      v_next = -v;
    end else if (n > max_s) begin
      p_next = COORD_W'((max_s <<< 1) - n);
      v_next = -v;
    end
  end

endmodule

// File: rtl/worley_point_animator.sv
// Serially moves N feature points once per accepted frame_start, then
// commits all positions and the frame counter together.
module worley_point_animator
  import worley_pkg::*;
#(
  parameter int unsigned N_POINTS = 4,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned VEL_W    = 4,
  parameter int unsigned X_MAX    = X_MAX_DEF,
  parameter int unsigned Y_MAX    = Y_MAX_DEF,
  parameter int unsigned TM_W     = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          freeze,
  output logic [N_POINTS*COORD_W-1:0]   points_x,
  output logic [N_POINTS*COORD_W-1:0]   points_y,
  output logic [TM_W-1:0]               tm,
  output logic                          busy,
  output logic                          update_done
);
  localparam int unsigned IDX_W = $clog2(N_POINTS);
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

  logic        [COORD_W-1:0] wx [N_POINTS];
  logic        [COORD_W-1:0] wy [N_POINTS];
  logic        [COORD_W-1:0] cx [N_POINTS];
  logic        [COORD_W-1:0] cy [N_POINTS];
  logic signed [VEL_W-1:0]   vx [N_POINTS];
  logic signed [VEL_W-1:0]   vy [N_POINTS];

  logic [IDX_W-1:0] idx;
  state_t           state;

  logic        [COORD_W-1:0] nx, ny;
  logic signed [VEL_W-1:0]   nvx, nvy;

  bounce_axis #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_bounce_x (
    .p(wx[idx]), .v(vx[idx]), .max_p(X_LIM), .p_next(nx), .v_next(nvx)
  );

  bounce_axis #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_bounce_y (
    .p(wy[idx]), .v(vy[idx]), .max_p(Y_LIM), .p_next(ny), .v_next(nvy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      tm          <= '0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      for (int unsigned i = 0; i < N_POINTS; i++) begin
        wx[i] <= COORD_W'(init_val(i, F_X));
        wy[i] <= COORD_W'(init_val(i, F_Y));
        cx[i] <= COORD_W'(init_val(i, F_X));
        cy[i] <= COORD_W'(init_val(i, F_Y));
        vx[i] <= VEL_W'(init_val(i, F_VX));
        vy[i] <= VEL_W'(init_val(i, F_VY));
      end
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start && !freeze) begin
            state <= UPDATE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          wx[idx] <= nx;
          wy[idx] <= ny;
          vx[idx] <= nvx;
          vy[idx] <= nvy;
          if (idx == IDX_W'(N_POINTS - 1)) state <= COMMIT;
          else                             idx   <= idx + IDX_W'(1);
        end
        COMMIT: begin
          cx          <= wx;
          cy          <= wy;
          tm          <= tm + TM_W'(1);
          busy        <= 1'b0;
          update_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    points_x = '0;
    points_y = '0;
    for (int unsigned i = 0; i < N_POINTS; i++) begin
      points_x[i*COORD_W +: COORD_W] = cx[i];
      points_y[i*COORD_W +: COORD_W] = cy[i];
    end
  end

endmodule

// File: tb/tb_worley_point_animator.sv
// Scoreboard bench: expected commits queued at frame issue, checked on update_done.
module tb_worley_point_animator;
  localparam int N  = 4;
  localparam int CW = 10;
  localparam int VW = 4;
  localparam int TW = 20;
  localparam int XM = 639;
  localparam int YM = 479;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              freeze = 1'b0;
  logic [N*CW-1:0]   points_x, points_y;
  logic [TW-1:0]     tm;
  logic              busy, update_done;

  worley_point_animator #(
    .N_POINTS(N), .COORD_W(CW), .VEL_W(VW), .X_MAX(XM), .Y_MAX(YM), .TM_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .freeze(freeze),
    .points_x(points_x), .points_y(points_y), .tm(tm),
    .busy(busy), .update_done(update_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*CW-1:0] x;
    logic [N*CW-1:0] y;
    logic [TW-1:0]   t;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int mx[N], my[N], mvx[N], mvy[N];
  int mtm;
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int reflect(input int p, inout int v, input int lim);
    int n;
    n = p + v;
    if (n < 0)   begin v = -v; return -n; end
    if (n > lim) begin v = -v; return 2 * lim - n; end
    return n;
  endfunction

  task automatic model_reset();
    int ix[4] = '{100, 300, 500, 100};
    int iy[4] = '{100, 200, 400, 430};
    int ivx[4] = '{3, -1, 2, -2};
    int ivy[4] = '{-2, 1, -1, -3};
    for (int i = 0; i < N; i++) begin
      mx[i] = ix[i % 4] + ((i >= 4) ? 8 : 0);
      my[i] = iy[i % 4];
      mvx[i] = ivx[i % 4];
      mvy[i] = ivy[i % 4];
    end
    mtm = 0;
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    int c;
    for (int i = 0; i < N; i++) begin
      c = mx[i]; e.x[i*CW +: CW] = c[CW-1:0];
      c = my[i]; e.y[i*CW +: CW] = c[CW-1:0];
    end
    c = mtm;
    e.t = c[TW-1:0];
    return e;
  endfunction

  task automatic model_frame();
    for (int i = 0; i < N; i++) begin
      mx[i] = reflect(mx[i], mvx[i], XM);
      my[i] = reflect(my[i], mvy[i], YM);
    end
    mtm = (mtm + 1) % (1 << TW);
  endtask

  task automatic send_frame();
    frame_start = 1'b1;
    freeze = 1'b0;
    tick();
    frame_start = 1'b0;
    model_frame();
    q.push_back(model_snapshot());
  endtask

  // Runs until busy drops; noisy adds ignored pulses and mid-update freeze.
  task automatic finish_frame(input bit noisy);
    int k = 0;
    while (busy && k < 20) begin
      if (noisy) begin
        frame_start = ($urandom_range(0, 2) == 0);
        freeze = 1'($urandom_range(0, 1));
      end
      tick();
      k++;
    end
    frame_start = 1'b0;
    freeze = 1'b0;
    if (busy) chk("busy_timeout", 1, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && update_done) begin
      if (q.size() == 0) begin
        chk("unexpected_commit", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("commit_x", points_x, mon_e.x);
        chk("commit_y", points_y, mon_e.y);
        chk("commit_tm", tm, mon_e.t);
      end
    end
  end

  initial begin
    exp_t snap;
    int old_tm;
    int k;

    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    snap = model_snapshot();
    chk("reset_x", points_x, snap.x);
    chk("reset_y", points_y, snap.y);
    chk("reset_tm", tm, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", update_done, 0);

    send_frame();
    chk("f1_busy_start", busy, 1);
    repeat (N) tick();
    chk("f1_busy_mid", busy, 1);
    chk("f1_tm_hold", tm, 0);
    chk("f1_done_early", update_done, 0);
    tick();
    chk("f1_busy_end", busy, 0);
    chk("f1_done", update_done, 1);
    chk("f1_tm", tm, 1);
    tick();
    chk("f1_done_pulse", update_done, 0);
    chk("f1_p0x", points_x[9:0], 103);
    chk("f1_p0y", points_y[9:0], 98);
    chk("f1_p1x", points_x[19:10], 299);
    chk("f1_p1y", points_y[19:10], 201);

    for (int f = 2; f <= 180; f++) begin
      send_frame();
      finish_frame(1'b1);
      if (f == 50)  chk("p3x_f50", points_x[39:30], 0);
      if (f == 51)  chk("p3x_f51", points_x[39:30], 2);
      if (f == 52)  chk("p3x_f52", points_x[39:30], 4);
      if (f == 179) chk("p0x_f179", points_x[9:0], 637);
      if (f == 180) chk("p0x_f180", points_x[9:0], 638);
      chk("p0y_range", points_y[9:0] <= YM, 1);
      repeat ($urandom_range(0, 2)) tick();
    end

    old_tm = int'(tm);
    send_frame();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    finish_frame(1'b0);
    repeat (3) tick();
    chk("double_pulse_tm", tm, old_tm + 1);
    chk("double_pulse_busy", busy, 0);
    chk("p0x_f181", points_x[9:0], 635);

    snap = model_snapshot();
    freeze = 1'b1;
    repeat (10) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      chk("freeze_busy", busy, 0);
    end
    freeze = 1'b0;
    chk("freeze_x", points_x, snap.x);
    chk("freeze_y", points_y, snap.y);
    chk("freeze_tm", tm, snap.t);

    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    model_reset();
    snap = model_snapshot();
    chk("midrst_x", points_x, snap.x);
    chk("midrst_y", points_y, snap.y);
    chk("midrst_tm", tm, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        frame_start = 1'b1;
        freeze = 1'b1;
        tick();
        frame_start = 1'b0;
        freeze = 1'b0;
        tick();
        chk("rand_freeze_busy", busy, 0);
      end else begin
        send_frame();
        finish_frame(1'b1);
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    k = 0;
    while (q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    chk("queue_drained", q.size(), 0);
    chk("final_tm", tm, mtm);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/worley_point_animator.md
# worley_point_animator

Per-frame animator for the Worley feature points. It moves N points with signed velocities, reflecting them off the screen edges, and maintains the frame counter `tm`. It sits directly upstream of the Worley noise generator and drives that block's point coordinates and time input. New positions are computed serially, one point per cycle, after each frame-start pulse, then committed atomically so the noise stage never sees a half-updated set.

## Interface
Parameters:
- `N_POINTS`, 4, number of feature points (2..8)
- `COORD_W`, 10, coordinate width
- `VEL_W`, 4, signed velocity width
- `X_MAX`, 639, largest legal x
- `Y_MAX`, 479, largest legal y
- `TM_W`, 20, frame counter width

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, synchronous, active-low
- `frame_start` in 1: single-cycle pulse from the sync generator at the start of vblank
- `freeze` in 1: when high, `frame_start` is ignored
- `points_x` out N_POINTS*COORD_W: committed x positions; point i at bits [i*COORD_W +: COORD_W]
- `points_y` out N_POINTS*COORD_W: committed y positions, same packing
- `tm` out TM_W: committed frame count
- `busy` out 1: update in progress
- `update_done` out 1: one-cycle pulse after commit

## Operation
- Reset values:
  - positions and velocities load the package init tables.
  - `tm` = 0.
  - `busy` = 0, `update_done` = 0.
  - FSM = IDLE.
- Init tables:
  - P0 (100,100), v(+3,−2)
  - P1 (300,200), v(−1,+1)
  - P2 (500,400), v(+2,−1)
  - P3 (100,430), v(−2,−3)
  - Points 4..7 reuse P0..P3 with x+8.
- FSM states:
  - IDLE → UPDATE when `frame_start` && !`freeze`.
  - UPDATE: index i runs 0..N_POINTS−1, one point per cycle, writing the working registers. Move to COMMIT after i = N_POINTS−1.
  - COMMIT: copy working positions to the output registers, set `tm` = `tm`+1, go to IDLE.
- Per-axis arithmetic, signed with COORD_W+2 bits: n = p + v.
  - If n < 0: p ← −n, v ← −v.
  - If n > MAX: p ← 2·MAX − n, v ← −v.
  - Otherwise: p ← n.
  - n = 0 or n = MAX is legal; no reflection.
- Velocity constraint: |v| ≤ 2^(VEL_W−1)−1. The most negative code is never loaded, so −v never overflows.
- v = 0 leaves the point static.
- `tm` wraps modulo 2^TM_W.

## Timing
- Cycle reference: `frame_start` is sampled high at edge E0.
  - `busy` is high from after E0 until after edge E0+N_POINTS+1.
  - Point i is updated at edge E0+1+i.
  - `points_x`, `points_y` and `tm` change only at edge E0+N_POINTS+1, all together.
  - `update_done` is high for the single cycle following that edge.
- `frame_start` while `busy`: ignored, with no queuing.
- `frame_start` and `freeze` high together: ignored.
- `freeze` rising mid-update: the update completes normally.
- `rst_n` low mid-update: on the next edge everything returns to reset values and the partial update is discarded.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Structure
- Package `worley_pkg`:
  - init position and velocity tables
  - FSM state enum (IDLE, UPDATE, COMMIT)
  - `X_MAX` / `Y_MAX` defaults
- Sub-module `bounce_axis` (combinational): inputs p, v, MAX; outputs p′, v′. The datapath instantiates two, one for x and one for y, shared across points through the index mux.
- Working and committed position arrays are separate register sets.

## Test plan
- Reset, then one `frame_start` → after 6 cycles P0 = (103,98), P1 = (299,201), `tm` = 1, `update_done` high for exactly 1 cycle.
- 51 frames → P3.x = 0 after frame 50 (no reflect) and 2 after frame 51, with vx = +2.
- 180 frames → P0.x goes 637 → 638 (n = 640 reflected), vx = −3; P0.y never leaves 0..479.
- `frame_start` pulsed again 2 cycles after the first → ignored, `tm` advances by 1 only.
- `freeze` = 1 with 10 pulses → outputs and `tm` unchanged.
- `rst_n` low during UPDATE at i = 2 → next cycle outputs equal the init tables, `tm` = 0, `busy` = 0.
